// File: rtl/mem_stage.sv
// Memory-access stage of the rv32im pipeline: runs load/store transfers on the
// req/ack data bus, formats load data and forwards the rd/csr writeback bundle.
module mem_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic            rd_we_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            csr_we_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_data_o,
  output logic            csr_we_o,
  output logic            stall_req_o,
  output logic            misaligned_o,
  output logic            bus_err_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_ack_i
);

  localparam int            CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit            TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] cap_data_q, cap_data_d;
  logic            cap_we_q, cap_we_d;
  logic            cap_err_q, cap_err_d;

  logic            access, is_load, is_store, size_b, size_h, sext, misalign;
  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_val, result, wdata;
  logic [3:0]      be;

  assign off      = rd_data_i[1:0];
  assign access   = mem_re_i | mem_we_i;
  assign is_load  = mem_re_i;
  assign is_store = mem_we_i & ~mem_re_i;
  assign size_b   = (mem_funct3_i[1:0] == 2'b00);
  assign size_h   = (mem_funct3_i[1:0] == 2'b01);
  assign sext     = ~mem_funct3_i[2];
  assign misalign = access & ((size_h & off[0]) | (~size_b & ~size_h & (off != 2'b00)));

  // Lane extraction, sign/zero extension and store-lane replication.
  always_comb begin
    case (off)
      2'b00:   ld_byte = dbus_rdata_i[7:0];
      2'b01:   ld_byte = dbus_rdata_i[15:8];
      2'b10:   ld_byte = dbus_rdata_i[23:16];
      default: ld_byte = dbus_rdata_i[31:24];
    endcase
    ld_half = off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    if (size_b) begin
      load_val = {{(XLEN-8){sext & ld_byte[7]}}, ld_byte};
      be       = 4'b0001 << off;
      wdata    = {(XLEN/8){mem_wdata_i[7:0]}};
    end else if (size_h) begin
      load_val = {{(XLEN-16){sext & ld_half[15]}}, ld_half};
      be       = off[1] ? 4'b1100 : 4'b0011;
      wdata    = {(XLEN/16){mem_wdata_i[15:0]}};
    end else begin
      load_val = dbus_rdata_i;
      be       = 4'b1111;
      wdata    = mem_wdata_i;
    end
    result = is_load ? load_val : rd_data_i;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_data_d   = cap_data_q;
    cap_we_d     = cap_we_q;
    cap_err_d    = cap_err_q;
    rd_addr_o    = rd_addr_i;
    rd_data_o    = rd_data_i;
    rd_we_o      = rd_we_i;
    csr_addr_o   = csr_addr_i;
    csr_data_o   = csr_data_i;
    csr_we_o     = csr_we_i;
    stall_req_o  = 1'b0;
    misaligned_o = 1'b0;
    bus_err_o    = 1'b0;
    dbus_req_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (misalign) begin
          misaligned_o = 1'b1;
          rd_we_o      = 1'b0;
        end else if (access) begin
          dbus_req_o = 1'b1;
          if (dbus_ack_i) begin
            rd_data_o  = result;
            cap_data_d = result;
            cap_we_d   = rd_we_i;
            cap_err_d  = 1'b0;
            if (stall_i) state_d = DONE;
          end else begin
            stall_req_o = 1'b1;
            rd_we_o     = 1'b0;
            cnt_d       = CW'(1);
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        if (dbus_ack_i) begin
          dbus_req_o = 1'b1;
          rd_data_o  = result;
          cap_data_d = result;
          cap_we_d   = rd_we_i;
          cap_err_d  = 1'b0;
          cnt_d      = '0;
          state_d    = stall_i ? DONE : IDLE;
        end else if (TO_EN && (cnt_q == CNT_TO)) begin
          bus_err_o  = 1'b1;
          rd_we_o    = 1'b0;
          cap_data_d = rd_data_i;
          cap_we_d   = 1'b0;
          cap_err_d  = 1'b1;
          cnt_d      = '0;
          state_d    = stall_i ? DONE : IDLE;
        end else begin
          dbus_req_o  = 1'b1;
          stall_req_o = 1'b1;
          rd_we_o     = 1'b0;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        rd_data_o = cap_data_q;
        rd_we_o   = cap_we_q;
        bus_err_o = cap_err_q;
        if (!stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dbus_we_o    = dbus_req_o & is_store;
    dbus_addr_o  = {rd_data_i[XLEN-1:2], 2'b00};
    dbus_be_o    = be;
    dbus_wdata_o = wdata;
    // Everything leaving the stage is held at zero while reset is asserted.
    if (!rst_ni) begin
      rd_addr_o    = '0;
      rd_data_o    = '0;
      rd_we_o      = 1'b0;
      csr_addr_o   = '0;
      csr_data_o   = '0;
      csr_we_o     = 1'b0;
      stall_req_o  = 1'b0;
      misaligned_o = 1'b0;
      bus_err_o    = 1'b0;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = '0;
      dbus_be_o    = '0;
      dbus_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_data_q <= '0;
      cap_we_q   <= 1'b0;
      cap_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_data_q <= cap_data_d;
      cap_we_q   <= cap_we_d;
      cap_err_q  <= cap_err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writeback results are queued when an
// access is launched and popped on the cycle the stage releases its stall.
module tb_mem_stage;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            stall_i;
  logic [4:0]      rd_addr_i;
  logic [XLEN-1:0] rd_data_i;
  logic            rd_we_i;
  logic            mem_re_i;
  logic            mem_we_i;
  logic [2:0]      mem_funct3_i;
  logic [XLEN-1:0] mem_wdata_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_data_i;
  logic            csr_we_i;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            rd_we_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_data_o;
  logic            csr_we_o;
  logic            stall_req_o;
  logic            misaligned_o;
  logic            bus_err_o;
  logic            dbus_req_o;
  logic            dbus_we_o;
  logic [XLEN-1:0] dbus_addr_o;
  logic [3:0]      dbus_be_o;
  logic [XLEN-1:0] dbus_wdata_o;
  logic [XLEN-1:0] dbus_rdata_i;
  logic            dbus_ack_i;

  mem_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
    .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rd_we_i(rd_we_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_funct3_i(mem_funct3_i),
    .mem_wdata_i(mem_wdata_i), .csr_addr_i(csr_addr_i), .csr_data_i(csr_data_i),
    .csr_we_i(csr_we_i), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .rd_we_o(rd_we_o), .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o),
    .csr_we_o(csr_we_o), .stall_req_o(stall_req_o), .misaligned_o(misaligned_o),
    .bus_err_o(bus_err_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic        we;
    logic        err;
  } expT;

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackDelay;
    logic [31:0] expData;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
  } vecT;

  expT expQ[$];
  vecT vecs[12];
  int  assertCount = 0;
  int  failCount   = 0;
  int  stalls;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    stall_i      = 1'b0;
    rd_addr_i    = '0;
    rd_data_i    = '0;
    rd_we_i      = 1'b0;
    mem_re_i     = 1'b0;
    mem_we_i     = 1'b0;
    mem_funct3_i = 3'b000;
    mem_wdata_i  = '0;
    csr_addr_i   = '0;
    csr_data_i   = '0;
    csr_we_i     = 1'b0;
    dbus_rdata_i = '0;
    dbus_ack_i   = 1'b0;
  endtask

  task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rdAddr, input logic [31:0] expData,
                               input logic expWe, input logic expErr);
    expT e;
    mem_re_i     = re;
    mem_we_i     = we;
    mem_funct3_i = f3;
    rd_data_i    = addr;
    mem_wdata_i  = wdata;
    rd_addr_i    = rdAddr;
    rd_we_i      = re;
    e.data = expData;
    e.we   = expWe;
    e.err  = expErr;
    expQ.push_back(e);
  endtask

  // Answers the request after ackDelay wait cycles (negative: never) and
  // checks the popped expectation on the cycle the stall is released.
  task automatic driveBus(input string tag, input int ackDelay, input logic [31:0] rdata,
                          output int nStalls);
    bit  done = 1'b0;
    expT e;
    nStalls = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      dbus_ack_i   = (k == ackDelay);
      dbus_rdata_i = (k == ackDelay) ? rdata : 32'h0BAD_F00D;
      @(negedge clk_i);
      if (stall_req_o) begin
        nStalls++;
        @(posedge clk_i);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checkOutput({tag, "_bound"}, 32'(stall_req_o), 0);
    end else if (expQ.size() == 0) begin
      checkOutput({tag, "_sb"}, 32'(expQ.size()), 1);
    end else begin
      e = expQ.pop_front();
      if (!e.err) checkOutput({tag, "_rd_data"}, rd_data_o, e.data);
      checkOutput({tag, "_rd_we"}, 32'(rd_we_o), 32'(e.we));
      checkOutput({tag, "_bus_err"}, 32'(bus_err_o), 32'(e.err));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    rd_we_i   = 1'b1;
    rd_data_i = 32'h1234;
    csr_we_i  = 1'b1;
    mem_re_i  = 1'b1;
    #2;
    checkOutput("rst_rd_we", 32'(rd_we_o), 0);
    checkOutput("rst_rd_data", rd_data_o, 0);
    checkOutput("rst_csr_we", 32'(csr_we_o), 0);
    checkOutput("rst_dbus_req", 32'(dbus_req_o), 0);
    clearInputs();
    #10 rst_ni = 1'b1;

    // Non-access instruction: everything passes straight through.
    @(posedge clk_i); #1;
    rd_addr_i = 5'd7; rd_data_i = 32'hA5A5_0001; rd_we_i = 1'b1;
    csr_addr_i = 12'h305; csr_data_i = 32'h8000_0100; csr_we_i = 1'b1;
    @(negedge clk_i);
    checkOutput("pass_rd_addr", 32'(rd_addr_o), 7);
    checkOutput("pass_rd_data", rd_data_o, 32'hA5A5_0001);
    checkOutput("pass_rd_we", 32'(rd_we_o), 1);
    checkOutput("pass_csr_addr", 32'(csr_addr_o), 32'h305);
    checkOutput("pass_csr_data", csr_data_o, 32'h8000_0100);
    checkOutput("pass_stall", 32'(stall_req_o), 0);
    checkOutput("pass_req", 32'(dbus_req_o), 0);

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 32'hDEADBEEF, 4'b1111, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80AABBCC, 0, 32'hFFFFFF80, 4'b1000, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80AABBCC, 0, 32'h00000080, 4'b1000, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80AABBCC, 0, 32'h000080AA, 4'b1100, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80AABBCC, 1, 32'hFFFF80AA, 4'b1100, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0,        0, 32'h00000206, 4'b1100, 32'hABCDABCD};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h1234ABCD, 32'h0,        1, 32'h00000201, 4'b0010, 32'hCDCDCDCD};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h208, 32'hCAFEF00D, 32'h0,        2, 32'h00000208, 4'b1111, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h80AABBCC, 0, 32'hFFFFFFBB, 4'b0010, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h80AABBCC, 0, 32'h0000BBCC, 4'b0011, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h00007FFF, 2, 32'h00007FFF, 4'b0011, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h80AABBCC, 0, 32'h000000AA, 4'b0100, 32'h0};

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      clearInputs();
      applyStimulus(vecs[i].re, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    5'(i + 1), vecs[i].expData, vecs[i].re, 1'b0);
      driveBus($sformatf("v%0d", i), vecs[i].ackDelay, vecs[i].rdata, stalls);
      checkOutput($sformatf("v%0d_stalls", i), stalls, vecs[i].ackDelay);
      checkOutput($sformatf("v%0d_req", i), 32'(dbus_req_o), 1);
      checkOutput($sformatf("v%0d_dbus_we", i), 32'(dbus_we_o), 32'(vecs[i].we));
      checkOutput($sformatf("v%0d_addr", i), dbus_addr_o, {vecs[i].addr[31:2], 2'b00});
      checkOutput($sformatf("v%0d_be", i), 32'(dbus_be_o), 32'(vecs[i].expBe));
      checkOutput($sformatf("v%0d_rd_addr", i), 32'(rd_addr_o), i + 1);
      if (vecs[i].we) checkOutput($sformatf("v%0d_wdata", i), dbus_wdata_o, vecs[i].expWdata);
    end

    // Misaligned word and half: no request, no writeback, no stall.
    @(posedge clk_i); #1;
    clearInputs();
    mem_re_i = 1'b1; mem_funct3_i = 3'b010; rd_data_i = 32'h101; rd_we_i = 1'b1; dbus_ack_i = 1'b1;
    @(negedge clk_i);
    checkOutput("mis_w_flag", 32'(misaligned_o), 1);
    checkOutput("mis_w_req", 32'(dbus_req_o), 0);
    checkOutput("mis_w_rd_we", 32'(rd_we_o), 0);
    checkOutput("mis_w_stall", 32'(stall_req_o), 0);
    @(posedge clk_i); #1;
    mem_funct3_i = 3'b101; rd_data_i = 32'h105;
    @(negedge clk_i);
    checkOutput("mis_h_flag", 32'(misaligned_o), 1);
    checkOutput("mis_h_req", 32'(dbus_req_o), 0);

    // Ack while stall_i is high: DONE holds the captured result.
    @(posedge clk_i); #1;
    clearInputs();
    stall_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd20, 32'h11223344, 1'b1, 1'b0);
    driveBus("done", 1, 32'h11223344, stalls);
    checkOutput("done_stalls", stalls, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      dbus_ack_i = 1'b0;
      dbus_rdata_i = 32'h5555_AAAA;
      if (c == 2) stall_i = 1'b0;
      @(negedge clk_i);
      checkOutput($sformatf("done_hold%0d_data", c), rd_data_o, 32'h11223344);
      checkOutput($sformatf("done_hold%0d_we", c), 32'(rd_we_o), 1);
      checkOutput($sformatf("done_hold%0d_req", c), 32'(dbus_req_o), 0);
      checkOutput($sformatf("done_hold%0d_stall", c), 32'(stall_req_o), 0);
    end
    @(posedge clk_i); #1;
    clearInputs();
    rd_data_i = 32'h0000_0055;
    @(negedge clk_i);
    checkOutput("done_exit_pass", rd_data_o, 32'h55);

    // Never acknowledged: bus error after TO wait cycles in BUSY.
    @(posedge clk_i); #1;
    clearInputs();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd9, 32'h0, 1'b0, 1'b1);
    driveBus("tmo", -1, 32'h0, stalls);
    checkOutput("tmo_stalls", stalls, TO);
    checkOutput("tmo_req", 32'(dbus_req_o), 0);
    @(posedge clk_i); #1;
    clearInputs();
    dbus_ack_i = 1'b1;
    rd_data_i  = 32'h77;
    @(negedge clk_i);
    checkOutput("tmo_after_err", 32'(bus_err_o), 0);
    checkOutput("tmo_late_ack_stall", 32'(stall_req_o), 0);
    checkOutput("tmo_late_ack_data", rd_data_o, 32'h77);

    // Reset asserted while BUSY, then the held access restarts from IDLE.
    @(posedge clk_i); #1;
    clearInputs();
    mem_re_i = 1'b1; mem_funct3_i = 3'b010; rd_data_i = 32'h500; rd_we_i = 1'b1;
    rd_addr_i = 5'd3; csr_we_i = 1'b1;
    repeat (3) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
    checkOutput("rbusy_stall_pre", 32'(stall_req_o), 1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("rbusy_stall", 32'(stall_req_o), 0);
    checkOutput("rbusy_req", 32'(dbus_req_o), 0);
    checkOutput("rbusy_csr_we", 32'(csr_we_o), 0);
    checkOutput("rbusy_rd_addr", 32'(rd_addr_o), 0);
    checkOutput("rbusy_addr", dbus_addr_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    expQ.push_back('{data: 32'h600DCAFE, we: 1'b1, err: 1'b0});
    driveBus("rbusy_restart", TO, 32'h600DCAFE, stalls);
    checkOutput("rbusy_restart_stalls", stalls, TO);

    @(posedge clk_i); #1;
    clearInputs();
    checkOutput("sb_drained", 32'(expQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the rv32im pipeline. Sits between the execute stage's EX/MEM register and the writeback register.
- Performs load/store transactions on the data bus using a req/ack handshake. Formats load data (byte/half extraction, sign/zero extension) and produces the rd/csr write-back bundle that writeback registers.
- Raises stall_req_o to pipectrl while a bus access is outstanding. Detects misaligned accesses and bus timeouts.

Parameters:
- XLEN, 32: data/address width (from defines.v).
- TIMEOUT_CYCLES, 16: wait cycles without ack before a bus error is declared. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- stall_i  in  1  MEM/WB stall from pipectrl (other stall sources)
- rd_addr_i  in  5  destination register from EX/MEM
- rd_data_i  in  XLEN  ALU result; effective address for loads/stores
- rd_we_i  in  1  register write enable
- mem_re_i  in  1  load
- mem_we_i  in  1  store
- mem_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_wdata_i  in  XLEN  store data (rs2)
- csr_addr_i  in  12  CSR write address
- csr_data_i  in  XLEN  CSR write data
- csr_we_i  in  1  CSR write enable
- rd_addr_o  out  5  to writeback
- rd_data_o  out  XLEN  to writeback
- rd_we_o  out  1  to writeback
- csr_addr_o  out  12  to writeback
- csr_data_o  out  XLEN  to writeback
- csr_we_o  out  1  to writeback
- stall_req_o  out  1  to pipectrl; freezes IF..MEM and writeback
- misaligned_o  out  1  misaligned access exception
- bus_err_o  out  1  bus timeout exception
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  XLEN  lane-aligned write data
- dbus_rdata_i  in  XLEN  read data, valid when dbus_ack_i=1
- dbus_ack_i  in  1  transfer complete

Behaviour:
- Reset (rst_ni low, async):
  - FSM goes to IDLE; timeout counter, captured data and captured error flag clear to 0.
  - While rst_ni is low, every output is forced to 0.
- Inputs are held stable by the upstream stage while stall_req_o=1 or stall_i=1.
- access = mem_re_i | mem_we_i. If both are set, the access is treated as a load.
- Misalignment:
  - Condition: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Response: no bus request; misaligned_o=1 combinationally; rd_we_o=0; stall_req_o=0.
- Byte enables:
  - B: 1<<addr[1:0]
  - H: addr[1] ? 1100 : 0011
  - W: 1111
- Store data: byte replicated to all 4 lanes; half replicated to both halves.
- Load result: lane selected by addr[1:0]. B/H sign-extended, BU/HU zero-extended, W passed through.
- Non-access instructions: all rd/csr outputs pass through combinationally; zero latency; no stall.
- FSM states IDLE, BUSY, DONE:
  - IDLE, aligned access:
    - dbus_req_o=1 combinationally.
    - If ack in the same cycle: output the formatted result. If stall_i=0, stay in IDLE; if stall_i=1, capture the result and go to DONE.
    - If no ack: stall_req_o=1, go to BUSY, count=1.
  - BUSY:
    - dbus_req_o=1; address, be and data held; stall_req_o=1 until ack.
    - On ack: stall_req_o=0 and the result is output. Then IDLE if stall_i=0, else capture and go to DONE.
    - On no ack: count increments.
  - Timeout (TIMEOUT_CYCLES>0, count==TIMEOUT_CYCLES with no ack):
    - dbus_req_o drops, bus_err_o=1, rd_we_o=0, stall_req_o=0.
    - Then IDLE if stall_i=0, else DONE with the error captured.
    - A late ack after timeout is ignored in IDLE only when no access is pending.
  - DONE:
    - dbus_req_o=0, stall_req_o=0.
    - Outputs come from the captured registers: rd_data, rd_we, and bus_err.
    - Return to IDLE on the first cycle with stall_i=0.
- The csr_* outputs always pass through from the inputs; they are never suppressed.
- Stores: rd_we_o = rd_we_i (normally 0).
- Counter width: $clog2(TIMEOUT_CYCLES+1); the counter never wraps.

Test Plan:
- LW at 0x100, ack after 3 cycles, dbus_rdata=0xDEADBEEF -> stall_req_o high for 3 cycles; rd_data_o=0xDEADBEEF on the ack cycle; rd_we_o=1.
- LB addr=0x103 with rdata=0x80AABBCC gives rd_data_o=0xFFFFFF80; LBU gives 0x00000080; LHU addr=0x102 gives 0x000080AA. Zero-wait ack -> no stall.
- SH addr=0x206, wdata=0x1234ABCD -> dbus_be_o=1100, dbus_wdata_o=0xABCDABCD, dbus_we_o=1, dbus_addr_o=0x204.
- LW addr=0x101 -> misaligned_o=1, dbus_req_o=0, rd_we_o=0, no stall.
- Ack arrives while stall_i=1 -> DONE holds rd_data_o stable across 2 stalled cycles; IDLE once stall_i=0.
- No ack with TIMEOUT_CYCLES=4 -> bus_err_o on the 4th wait cycle, request dropped. Separately, rst_ni low mid-BUSY -> all outputs 0 and the next access starts from IDLE.
